// File: rtl/serial_pkg.sv
// Encodings shared by the serial link receiver and transmitter.
package serial_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} rx_state_t;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

   typedef enum logic [1:0] {SH_HOLD, SH_CLEAR, SH_LEFT, SH_RIGHT} shift_op_t;
endpackage

// File: rtl/rx_shift_core.sv
// WIDTH-bit shift register with clear/hold/shift-left/shift-right; exposes its next value
// so the completing bit can be captured on the same edge it is shifted in.
module rx_shift_core
   import serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  shift_op_t        op,
   input  logic             din,
   output logic [WIDTH-1:0] nxt
);
   logic [WIDTH-1:0] sr;

   always_comb begin
      nxt = sr;
      case (op)
         SH_CLEAR: nxt = '0;
         SH_LEFT:  nxt = {sr[WIDTH-2:0], din};
         SH_RIGHT: nxt = {din, sr[WIDTH-1:1]};
         default:  nxt = sr;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= '0;
      else     sr <= nxt;
   end
endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with a one-entry valid/ready output buffer,
// sticky overrun and a one-cycle reframe pulse.
module serial_word_rx
   import serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             sin_start,
   input  logic             lsb_first,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy,
   output logic             overrun,
   input  logic             ovr_clr,
   output logic             frame_err
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   rx_state_t        state, state_nxt;
   logic [CNT_W-1:0] count;
   logic             dir_q, dir_use;
   logic             start, take_bit, complete, reframe;
   shift_op_t        op;
   logic [WIDTH-1:0] word;

   assign start = sin_valid && sin_start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start)         state_nxt = ST_SHIFT;
      else if (complete) state_nxt = ST_IDLE;
   end

   // A start bit uses the live direction input; later bits use the latched one.
   always_comb begin
      busy     = (state == ST_SHIFT);
      take_bit = start || (sin_valid && state == ST_SHIFT);
      dir_use  = sin_start ? lsb_first : dir_q;
      op       = SH_HOLD;
      if (take_bit) op = (dir_use == DIR_LSB_FIRST) ? SH_RIGHT : SH_LEFT;
      complete = (state == ST_SHIFT) && sin_valid && !sin_start && (count == LAST);
      reframe  = (state == ST_SHIFT) && start;
   end

   rx_shift_core #(.WIDTH(WIDTH)) u_core (
      .clk (clk),
      .rst (rst),
      .op  (op),
      .din (sin),
      .nxt (word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         dir_q <= DIR_MSB_FIRST;
      end else if (start) begin
         count <= CNT_W'(1);
         dir_q <= lsb_first;
      end else if (complete) begin
         count <= '0;
      end else if (take_bit) begin
         count <= count + CNT_W'(1);
      end
   end

   // Output buffer: a full, unaccepted buffer drops the new word and flags overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data    <= '0;
         m_valid   <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= reframe;
         if (complete) begin
            if (!m_valid || m_ready) begin
               m_data  <= word;
               m_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
         if (ovr_clr && !(complete && m_valid && !m_ready)) overrun <= 1'b0;
      end
   end
endmodule
